color_centroid_tracker: RTL and testbench

COLOR_CENTROID_TRACKER -- requirements
Module: color_centroid_tracker

---
 rtl/color_centroid_tracker.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_color_centroid_tracker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_centroid_tracker.sv
`default_nettype none
// ============================================================================
// Module   : color_centroid_tracker
// Brief    : Per-frame colour-match count and centroid over a raster RGB stream.
//            Optional bounding box tracking is built when CENTROID_BBOX_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module color_centroid_tracker #(
   parameter int WIDTH       = 640,
   parameter int HEIGHT      = 480,
   parameter int PIXEL_DEPTH = 8,
   parameter int MIN_COUNT   = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   valid_i,
   input  logic [PIXEL_DEPTH-1:0] input_R,
   input  logic [PIXEL_DEPTH-1:0] input_G,
   input  logic [PIXEL_DEPTH-1:0] input_B,
   input  logic [PIXEL_DEPTH-1:0] thr_R_min,
   input  logic [PIXEL_DEPTH-1:0] thr_G_max,
   input  logic [PIXEL_DEPTH-1:0] thr_B_max,
   output logic                   result_valid,
   output logic                   found,
   output logic [9:0]             centroid_x,
   output logic [8:0]             centroid_y,
   output logic [18:0]            pixel_count,
   output logic                   frame_dropped,
   output logic [9:0]             bbox_x_min,
   output logic [9:0]             bbox_x_max,
   output logic [8:0]             bbox_y_min,
   output logic [8:0]             bbox_y_max
);
   localparam logic [9:0]  COL_LAST  = 10'(WIDTH - 1);
   localparam logic [8:0]  ROW_LAST  = 9'(HEIGHT - 1);
   localparam logic [18:0] MIN_CNT   = 19'(MIN_COUNT);
   localparam logic [4:0]  STEP_LAST = 5'd27;

   typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;
   state_t state_q, state_d;

   logic [9:0]  col_q, col_d;
   logic [8:0]  row_q, row_d;
   logic [18:0] count_q, count_d;
   logic [27:0] sum_x_q, sum_x_d;
   logic [27:0] sum_y_q, sum_y_d;
   logic [18:0] divisor_q, divisor_d;
   logic [27:0] sum_y_snap_q, sum_y_snap_d;
   logic [27:0] dvd_q, dvd_d;
   logic [18:0] rem_q, rem_d;
   logic [9:0]  quot_x_q, quot_x_d;
   logic [4:0]  step_q, step_d;
   logic        result_valid_q, result_valid_d;
   logic        found_q, found_d;
   logic [9:0]  centroid_x_q, centroid_x_d;
   logic [8:0]  centroid_y_q, centroid_y_d;
   logic [18:0] pixel_count_q, pixel_count_d;
   logic        frame_dropped_q, frame_dropped_d;

   logic        w_match, w_hit, w_eof, w_snap, w_done_skip, w_done_div, w_ge;
   logic [18:0] w_count_tot;
   logic [27:0] w_sum_x_tot, w_sum_y_tot, w_dvd_next;
   logic [19:0] w_trial;

   assign w_match     = (input_R >= thr_R_min) && (input_G <= thr_G_max) && (input_B <= thr_B_max);
   assign w_hit       = valid_i && w_match;
   assign w_eof       = valid_i && (col_q == COL_LAST) && (row_q == ROW_LAST);
   assign w_count_tot = count_q + {18'd0, w_hit};
   assign w_sum_x_tot = sum_x_q + (w_hit ? {18'd0, col_q} : 28'd0);
   assign w_sum_y_tot = sum_y_q + (w_hit ? {19'd0, row_q} : 28'd0);
   assign w_snap      = w_eof && (state_q == IDLE);
   assign w_done_skip = w_snap && (w_count_tot < MIN_CNT);
   assign w_done_div  = (state_q == DIV_Y) && (step_q == STEP_LAST);

   // One restoring step: the dividend shifts out the top while quotient bits shift in below.
   assign w_trial    = {rem_q, dvd_q[27]};
   assign w_ge       = w_trial >= {1'b0, divisor_q};
   assign w_dvd_next = {dvd_q[26:0], w_ge};

   always_comb begin
      state_d         = state_q;
      col_d           = col_q;
      row_d           = row_q;
      count_d         = count_q;
      sum_x_d         = sum_x_q;
      sum_y_d         = sum_y_q;
      divisor_d       = divisor_q;
      sum_y_snap_d    = sum_y_snap_q;
      dvd_d           = dvd_q;
      rem_d           = rem_q;
      quot_x_d        = quot_x_q;
      step_d          = step_q;
      result_valid_d  = 1'b0;
      found_d         = found_q;
      centroid_x_d    = centroid_x_q;
      centroid_y_d    = centroid_y_q;
      pixel_count_d   = pixel_count_q;
      frame_dropped_d = w_eof && (state_q != IDLE);

      if (valid_i) begin
         if (col_q == COL_LAST) begin
            col_d = 10'd0;
            row_d = (row_q == ROW_LAST) ? 9'd0 : row_q + 9'd1;
         end else begin
            col_d = col_q + 10'd1;
         end
         if (w_eof) begin
            count_d = 19'd0;
            sum_x_d = 28'd0;
            sum_y_d = 28'd0;
         end else begin
            count_d = w_count_tot;
            sum_x_d = w_sum_x_tot;
            sum_y_d = w_sum_y_tot;
         end
      end

      case (state_q)
         IDLE: begin
            if (w_snap) begin
               divisor_d    = w_count_tot;
               dvd_d        = w_sum_x_tot;
               sum_y_snap_d = w_sum_y_tot;
               rem_d        = 19'd0;
               step_d       = 5'd0;
               if (w_done_skip) begin
                  state_d        = DONE;
                  result_valid_d = 1'b1;
                  found_d        = 1'b0;
                  pixel_count_d  = w_count_tot;
                  centroid_x_d   = 10'd0;
                  centroid_y_d   = 9'd0;
               end else begin
                  state_d = DIV_X;
               end
            end
         end
         DIV_X: begin
            rem_d  = 19'(w_ge ? w_trial - {1'b0, divisor_q} : w_trial);
            dvd_d  = w_dvd_next;
            step_d = step_q + 5'd1;
            if (step_q == STEP_LAST) begin
               quot_x_d = w_dvd_next[9:0];
               dvd_d    = sum_y_snap_q;
               rem_d    = 19'd0;
               step_d   = 5'd0;
               state_d  = DIV_Y;
            end
         end
         DIV_Y: begin
            rem_d  = 19'(w_ge ? w_trial - {1'b0, divisor_q} : w_trial);
            dvd_d  = w_dvd_next;
            step_d = step_q + 5'd1;
            if (w_done_div) begin
               state_d        = DONE;
               result_valid_d = 1'b1;
               found_d        = 1'b1;
               pixel_count_d  = divisor_q;
               centroid_x_d   = quot_x_q;
               centroid_y_d   = w_dvd_next[8:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         col_q           <= '0;
         row_q           <= '0;
         count_q         <= '0;
         sum_x_q         <= '0;
         sum_y_q         <= '0;
         divisor_q       <= '0;
         sum_y_snap_q    <= '0;
         dvd_q           <= '0;
         rem_q           <= '0;
         quot_x_q        <= '0;
         step_q          <= '0;
         result_valid_q  <= 1'b0;
         found_q         <= 1'b0;
         centroid_x_q    <= '0;
         centroid_y_q    <= '0;
         pixel_count_q   <= '0;
         frame_dropped_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         col_q           <= col_d;
         row_q           <= row_d;
         count_q         <= count_d;
         sum_x_q         <= sum_x_d;
         sum_y_q         <= sum_y_d;
         divisor_q       <= divisor_d;
         sum_y_snap_q    <= sum_y_snap_d;
         dvd_q           <= dvd_d;
         rem_q           <= rem_d;
         quot_x_q        <= quot_x_d;
         step_q          <= step_d;
         result_valid_q  <= result_valid_d;
         found_q         <= found_d;
         centroid_x_q    <= centroid_x_d;
         centroid_y_q    <= centroid_y_d;
         pixel_count_q   <= pixel_count_d;
         frame_dropped_q <= frame_dropped_d;
      end
   end

   assign result_valid  = result_valid_q;
   assign found         = found_q;
   assign centroid_x    = centroid_x_q;
   assign centroid_y    = centroid_y_q;
   assign pixel_count   = pixel_count_q;
   assign frame_dropped = frame_dropped_q;

`ifdef CENTROID_BBOX_EN
   logic [9:0] bx_min_q, bx_min_d, bx_max_q, bx_max_d;
   logic [8:0] by_min_q, by_min_d, by_max_q, by_max_d;
   logic [9:0] sbx_min_q, sbx_min_d, sbx_max_q, sbx_max_d;
   logic [8:0] sby_min_q, sby_min_d, sby_max_q, sby_max_d;
   logic [9:0] obx_min_q, obx_min_d, obx_max_q, obx_max_d;
   logic [8:0] oby_min_q, oby_min_d, oby_max_q, oby_max_d;
   logic [9:0] w_bx_min_tot, w_bx_max_tot;
   logic [8:0] w_by_min_tot, w_by_max_tot;

   assign w_bx_min_tot = (w_hit && col_q < bx_min_q) ? col_q : bx_min_q;
   assign w_bx_max_tot = (w_hit && col_q > bx_max_q) ? col_q : bx_max_q;
   assign w_by_min_tot = (w_hit && row_q < by_min_q) ? row_q : by_min_q;
   assign w_by_max_tot = (w_hit && row_q > by_max_q) ? row_q : by_max_q;

   always_comb begin
      bx_min_d  = bx_min_q;
      bx_max_d  = bx_max_q;
      by_min_d  = by_min_q;
      by_max_d  = by_max_q;
      sbx_min_d = sbx_min_q;
      sbx_max_d = sbx_max_q;
      sby_min_d = sby_min_q;
      sby_max_d = sby_max_q;
      obx_min_d = obx_min_q;
      obx_max_d = obx_max_q;
      oby_min_d = oby_min_q;
      oby_max_d = oby_max_q;
      if (valid_i) begin
         bx_min_d = w_eof ? COL_LAST : w_bx_min_tot;
         bx_max_d = w_eof ? 10'd0    : w_bx_max_tot;
         by_min_d = w_eof ? ROW_LAST : w_by_min_tot;
         by_max_d = w_eof ? 9'd0     : w_by_max_tot;
      end
      if (w_snap) begin
         sbx_min_d = w_bx_min_tot;
         sbx_max_d = w_bx_max_tot;
         sby_min_d = w_by_min_tot;
         sby_max_d = w_by_max_tot;
      end
      if (w_done_skip) begin
         obx_min_d = 10'd0;
         obx_max_d = 10'd0;
         oby_min_d = 9'd0;
         oby_max_d = 9'd0;
      end else if (w_done_div) begin
         obx_min_d = sbx_min_q;
         obx_max_d = sbx_max_q;
         oby_min_d = sby_min_q;
         oby_max_d = sby_max_q;
      end
   end

   // Trackers come out of reset at their frame-start values, since a frame starts at release.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bx_min_q  <= COL_LAST;
         bx_max_q  <= '0;
         by_min_q  <= ROW_LAST;
         by_max_q  <= '0;
         sbx_min_q <= '0;
         sbx_max_q <= '0;
         sby_min_q <= '0;
         sby_max_q <= '0;
         obx_min_q <= '0;
         obx_max_q <= '0;
         oby_min_q <= '0;
         oby_max_q <= '0;
      end else begin
         bx_min_q  <= bx_min_d;
         bx_max_q  <= bx_max_d;
         by_min_q  <= by_min_d;
         by_max_q  <= by_max_d;
         sbx_min_q <= sbx_min_d;
         sbx_max_q <= sbx_max_d;
         sby_min_q <= sby_min_d;
         sby_max_q <= sby_max_d;
         obx_min_q <= obx_min_d;
         obx_max_q <= obx_max_d;
         oby_min_q <= oby_min_d;
         oby_max_q <= oby_max_d;
      end
   end

   assign bbox_x_min = obx_min_q;
   assign bbox_x_max = obx_max_q;
   assign bbox_y_min = oby_min_q;
   assign bbox_y_max = oby_max_q;
`else
   assign bbox_x_min = 10'd0;
   assign bbox_x_max = 10'd0;
   assign bbox_y_min = 9'd0;
   assign bbox_y_max = 9'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_color_centroid_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_color_centroid_tracker
// Brief    : Directed self-checking bench for color_centroid_tracker (three sizings).
// Revision : 1.0 - initial release
// ============================================================================
module tb_color_centroid_tracker;
   localparam int W0 = 112, H0 = 56;
   localparam int W1 = 640, H1 = 4;
   localparam int W2 = 8,   H2 = 2;
`ifdef CENTROID_BBOX_EN
   localparam bit BBOX_ON = 1'b1;
`else
   localparam bit BBOX_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       vld;
   logic       red;
   logic [1:0] sel;
   logic [7:0] in_r, in_g, in_b;
   logic [7:0] thr_r, thr_g, thr_b;
   logic [2:0] v_w, rv_w, fd_w, dr_w;
   logic [9:0] cx_w [3];
   logic [8:0] cy_w [3];
   logic [18:0] pc_w [3];
   logic [9:0] bx0_w [3], bx1_w [3];
   logic [8:0] by0_w [3], by1_w [3];

   assign in_r  = red ? 8'd255 : 8'd0;
   assign in_g  = 8'd0;
   assign in_b  = 8'd0;
   assign thr_r = 8'd200;
   assign thr_g = 8'd50;
   assign thr_b = 8'd50;
   assign v_w   = {vld && sel == 2'd2, vld && sel == 2'd1, vld && sel == 2'd0};

   color_centroid_tracker #(.WIDTH(W0), .HEIGHT(H0), .PIXEL_DEPTH(8), .MIN_COUNT(16)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .valid_i(v_w[0]),
      .input_R(in_r), .input_G(in_g), .input_B(in_b),
      .thr_R_min(thr_r), .thr_G_max(thr_g), .thr_B_max(thr_b),
      .result_valid(rv_w[0]), .found(fd_w[0]), .centroid_x(cx_w[0]), .centroid_y(cy_w[0]),
      .pixel_count(pc_w[0]), .frame_dropped(dr_w[0]),
      .bbox_x_min(bx0_w[0]), .bbox_x_max(bx1_w[0]), .bbox_y_min(by0_w[0]), .bbox_y_max(by1_w[0]));

   color_centroid_tracker #(.WIDTH(W1), .HEIGHT(H1), .PIXEL_DEPTH(8), .MIN_COUNT(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .valid_i(v_w[1]),
      .input_R(in_r), .input_G(in_g), .input_B(in_b),
      .thr_R_min(thr_r), .thr_G_max(thr_g), .thr_B_max(thr_b),
      .result_valid(rv_w[1]), .found(fd_w[1]), .centroid_x(cx_w[1]), .centroid_y(cy_w[1]),
      .pixel_count(pc_w[1]), .frame_dropped(dr_w[1]),
      .bbox_x_min(bx0_w[1]), .bbox_x_max(bx1_w[1]), .bbox_y_min(by0_w[1]), .bbox_y_max(by1_w[1]));

   color_centroid_tracker #(.WIDTH(W2), .HEIGHT(H2), .PIXEL_DEPTH(8), .MIN_COUNT(16)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .valid_i(v_w[2]),
      .input_R(in_r), .input_G(in_g), .input_B(in_b),
      .thr_R_min(thr_r), .thr_G_max(thr_g), .thr_B_max(thr_b),
      .result_valid(rv_w[2]), .found(fd_w[2]), .centroid_x(cx_w[2]), .centroid_y(cy_w[2]),
      .pixel_count(pc_w[2]), .frame_dropped(dr_w[2]),
      .bbox_x_min(bx0_w[2]), .bbox_x_max(bx1_w[2]), .bbox_y_min(by0_w[2]), .bbox_y_max(by1_w[2]));

   logic        rv, fd, dr;
   logic [9:0]  cx;
   logic [8:0]  cy;
   logic [18:0] pc;
   logic [37:0] bb;
   assign rv = rv_w[sel];
   assign fd = fd_w[sel];
   assign dr = dr_w[sel];
   assign cx = cx_w[sel];
   assign cy = cy_w[sel];
   assign pc = pc_w[sel];
   assign bb = {bx0_w[sel], bx1_w[sel], by0_w[sel], by1_w[sel]};

   typedef struct {
      logic [1:0] sel;
      int x0, x1, y0, y1;
      bit toggle;
      bit found;
      int cnt, cx, cy;
      int bx0, bx1, by0, by1;
      int lat;
   } vec_t;
   vec_t tbl [6];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [37:0] exp_bb(input bit f, input int x0, x1, y0, y1);
      if (BBOX_ON && f) return {10'(x0), 10'(x1), 9'(y0), 9'(y1)};
      return 38'd0;
   endfunction

   // Streams one full raster frame on the selected instance; red inside the given rectangle.
   task automatic run_frame(input int x0, x1, y0, y1, input bit toggle);
      int w, h;
      w = (sel == 2'd0) ? W0 : (sel == 2'd1) ? W1 : W2;
      h = (sel == 2'd0) ? H0 : (sel == 2'd1) ? H1 : H2;
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            vld = 1'b1;
            red = (x >= x0 && x <= x1 && y >= y0 && y <= y1);
            tick();
            if (toggle && !(x == w - 1 && y == h - 1)) begin
               vld = 1'b0;
               red = 1'b1;
               tick();
            end
         end
      end
      vld = 1'b0;
      red = 1'b0;
   endtask

   // Entered in cycle T+1; n counts the cycle offset from the end-of-frame pixel.
   task automatic check_result(input string name, input bit f, input int cnt, ecx, ecy,
                               input logic [37:0] ebb, input int lat);
      int n;
      n = 1;
      while (rv !== 1'b1 && n < 120) begin
         tick();
         n++;
      end
      if (rv !== 1'b1) begin
         chk({name, "_timeout"}, 64'(rv), 64'd1);
         return;
      end
      chk({name, "_latency"}, 64'(n), 64'(lat));
      chk({name, "_found"}, 64'(fd), 64'(f));
      chk({name, "_count"}, 64'(pc), 64'(cnt));
      chk({name, "_cx"}, 64'(cx), 64'(ecx));
      chk({name, "_cy"}, 64'(cy), 64'(ecy));
      chk({name, "_bbox"}, 64'(bb), 64'(ebb));
      tick();
      chk({name, "_strobe_len"}, 64'(rv), 64'd0);
      chk({name, "_hold_count"}, 64'(pc), 64'(cnt));
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_rv, n_dr, rv_cyc, dr1, dr2;
      logic        c_fd;
      logic [18:0] c_pc;
      logic [9:0]  c_cx;
      logic [8:0]  c_cy;
      logic [37:0] c_bb;

      tbl[0] = '{2'd0, 100, 103, 50, 53, 1'b0, 1'b1, 16, 101, 51, 100, 103, 50, 53, 57};
      tbl[1] = '{2'd0,  10,  14,  0,  2, 1'b0, 1'b0, 15,   0,  0,   0,   0,  0,  0,  1};
      tbl[2] = '{2'd0, 100, 103, 50, 53, 1'b1, 1'b1, 16, 101, 51, 100, 103, 50, 53, 57};
      tbl[3] = '{2'd0,   0,   7, 52, 55, 1'b0, 1'b1, 32,   3, 53,   0,   7, 52, 55, 57};
      tbl[4] = '{2'd0, 108, 111, 52, 55, 1'b0, 1'b1, 16, 109, 53, 108, 111, 52, 55, 57};
      tbl[5] = '{2'd1, 639, 639,  3,  3, 1'b0, 1'b1,  1, 639,  3, 639, 639,  3,  3, 57};

      reset_n = 1'b0;
      vld     = 1'b0;
      red     = 1'b0;
      sel     = 2'd0;
      repeat (3) tick();
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #1;
         chk($sformatf("reset_outputs%0d", s), 64'({rv, fd, dr, cx, cy, pc}), 64'd0);
         chk($sformatf("reset_bbox%0d", s), 64'(bb), 64'd0);
      end
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         sel = tbl[i].sel;
         run_frame(tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1, tbl[i].toggle);
         check_result($sformatf("vec%0d", i), tbl[i].found, tbl[i].cnt, tbl[i].cx, tbl[i].cy,
                      exp_bb(tbl[i].found, tbl[i].bx0, tbl[i].bx1, tbl[i].by0, tbl[i].by1), tbl[i].lat);
      end

      // Back-to-back all-red 8x2 frames: frames 2 and 3 end while dividing.
      sel = 2'd2;
      n_rv = 0; n_dr = 0; rv_cyc = -1; dr1 = -1; dr2 = -1;
      c_fd = 1'b0; c_pc = '0; c_cx = '0; c_cy = '0; c_bb = '0;
      for (int t = 0; t < 148; t++) begin
         vld = (t < 48);
         red = (t < 48);
         if (rv === 1'b1) begin
            n_rv++;
            rv_cyc = t;
            c_fd = fd; c_pc = pc; c_cx = cx; c_cy = cy; c_bb = bb;
         end
         if (dr === 1'b1) begin
            n_dr++;
            if (dr1 < 0) dr1 = t;
            else dr2 = t;
         end
         tick();
      end
      vld = 1'b0;
      red = 1'b0;
      chk("drop_n_result", 64'(n_rv), 64'd1);
      chk("drop_result_cycle", 64'(rv_cyc), 64'd72);
      chk("drop_n_dropped", 64'(n_dr), 64'd2);
      chk("drop_first_cycle", 64'(dr1), 64'd32);
      chk("drop_second_cycle", 64'(dr2), 64'd48);
      chk("drop_found", 64'(c_fd), 64'd1);
      chk("drop_count", 64'(c_pc), 64'd16);
      chk("drop_cx", 64'(c_cx), 64'd3);
      chk("drop_cy", 64'(c_cy), 64'd0);
      chk("drop_bbox", 64'(c_bb), 64'(exp_bb(1'b1, 0, 7, 0, 1)));

      // Mid-frame reset: stray red pixels and the raster position must be discarded.
      sel = 2'd0;
      for (int i = 0; i < 500; i++) begin
         vld = 1'b1;
         red = (i % 7 == 0);
         tick();
      end
      vld = 1'b0;
      red = 1'b0;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      run_frame(100, 103, 50, 53, 1'b0);
      check_result("after_midframe_reset", 1'b1, 16, 101, 51, exp_bb(1'b1, 100, 103, 50, 53), 57);

      // Reset at T+20 aborts the division.
      run_frame(100, 103, 50, 53, 1'b0);
      n_rv = 0;
      for (int n = 1; n <= 80; n++) begin
         reset_n = (n != 20);
         if (rv === 1'b1) n_rv++;
         tick();
      end
      reset_n = 1'b1;
      chk("abort_no_result", 64'(n_rv), 64'd0);
      chk("abort_outputs_cleared", 64'({fd, cx, cy, pc}), 64'd0);
      run_frame(100, 103, 50, 53, 1'b0);
      check_result("after_abort", 1'b1, 16, 101, 51, exp_bb(1'b1, 100, 103, 50, 53), 57);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
